psum_accum_buffer: RTL and testbench
====================================

// Module: psum_accum_buffer
// PURPOSE
//   Parametrised partial-sum accumulation buffer sitting between the PE array column outputs and the output/writeback path.
//   Performs read-add-write accumulation of ARRAY_DIM lanes per address, with RAW hazard forwarding and optional signed saturation.
//   Provides a handshaked, lower-priority readout port with optional clear-on-read and a whole-buffer clear sequencer.
// PARAMETERS
//   ARRAY_DIM   16    lanes per word (PE array columns)
//   ACC_WIDTH   32    bits per lane, two's complement
//   DEPTH       1024  words (spatial positions)
//   ADDR_WIDTH  10    address bits, DEPTH <= 2**ADDR_WIDTH
//   SATURATE    0     0: wrap-around add; 1: signed saturating add
// PORTS
//   clk         in   1                    clock, all logic on rising edge
//   rst         in   1                    synchronous reset, active-high
//   acc_valid   in   1                    accumulate request this cycle
//   acc_clear   in   1                    with acc_valid: overwrite instead of add
//   acc_addr    in   ADDR_WIDTH           accumulate address
//   psum_in     in   ARRAY_DIM*ACC_WIDTH  lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   rd_req      in   1                    readout request
//   rd_clear    in   1                    with accepted rd_req: zero word after reading
//   rd_addr     in   ADDR_WIDTH           readout address
//   rd_ready    out  1                    rd_req accepted this cycle (combinational)
//   rd_valid    out  1                    rd_data valid, one-cycle pulse
//   rd_data     out  ARRAY_DIM*ACC_WIDTH  readout word
//   clear_all   in   1                    start whole-buffer zeroing
//   busy        out  1                    clear sequencer active
//   sat_flag    out  1                    sticky: any lane saturated since reset
// BEHAVIOUR
//   Reset: rd_valid=0, rd_data=0, busy=0, sat_flag=0, pipeline valids=0, FSM=IDLE. Memory contents are not reset.
//   Pipeline: issue at edge T registers the op and reads mem into S1.
//     At T+1, S2 computes and writes mem. Issue-to-write latency is 2 edges.
//   Throughput: one op per cycle, accumulate or read.
//   Priority: acc_valid beats rd_req. rd_ready = rd_req & ~acc_valid & ~busy.
//     A request without rd_ready is not accepted; the requester holds it.
//   Accumulate: lane-wise word = acc_clear ? psum_in : old + psum_in.
//   SATURATE=0: sum is truncated mod 2**ACC_WIDTH.
//   SATURATE=1: signed overflow clamps to +max/-min and sets sat_flag. sat_flag clears only on rst.
//   Readout: rd_data is registered 2 edges after acceptance. It carries the value including every op accepted earlier.
//     rd_valid is high for exactly that cycle.
//   rd_clear: S2 writes all-zero to the read address.
//   RAW forwarding: if an op's read address equals the address being written at the same edge, S1 takes the S2 write data, not mem.
//     Any sequence (back-to-back, gap 1, gap 2+) to one address gives the exact sequential result.
//   FSM IDLE->CLEAR on clear_all while IDLE.
//     CLEAR writes zero to addr 0..DEPTH-1, one per cycle; busy=1 throughout.
//     Returns to IDLE after writing DEPTH-1; busy falls the next cycle, DEPTH cycles total.
//   During CLEAR: acc_valid and rd_req are ignored and must not be driven by upstream; rd_ready=0.
//     Ops already in S1/S2 at entry complete first, and the sweep starts after S2 drains.
//     clear_all while busy is ignored.
//   Out-of-range address (>= DEPTH): write dropped, read returns 0.
//   Reset mid-operation: in-flight S1/S2 ops and the CLEAR sweep are abandoned, busy=0 next cycle. Partially written memory is left as is.
// TESTING
//   Back-to-back RAW: acc addr 5: clear+10, then +3, +4 on consecutive cycles; read 5 -> every lane 17.
//   Gap-1/gap-2 RAW: same as above with one and two idle cycles between ops -> 17 in every case.
//   Saturation: SATURATE=1, lane0 0x7FFFFFF0 + 0x20 -> 0x7FFFFFFF, sat_flag=1. SATURATE=0 -> 0x80000010, sat_flag=0.
//   Arbitration: acc_valid and rd_req together -> rd_ready=0. Held rd_req is accepted the next free cycle, rd_valid 2 cycles later.
//     rd_clear then second read -> 0.
//   Clear-all: fill addrs 0..DEPTH-1, pulse clear_all -> busy for DEPTH cycles, every read returns 0.
//   Reset mid-clear: assert rst at sweep cycle 100 -> busy=0, rd_valid=0; addr 150 keeps its pre-clear value.

Source files
------------

// File: rtl/psum_accum_buffer_if.sv
// -----------------------------------------------------------------------------
// psum_accum_buffer_if
//   Bundles the accumulate, readout and clear-control signals of the partial-sum
//   accumulation buffer into one port.
//   master : the upstream side (PE array, output/writeback controller)
//   slave  : the buffer itself
// Signals
//   acc_valid/acc_clear/acc_addr/psum_in : accumulate request (master -> slave)
//   rd_req/rd_clear/rd_addr              : readout request    (master -> slave)
//   rd_ready                             : readout accepted this cycle
//   rd_valid/rd_data                     : readout result, one-cycle pulse
//   clear_all                            : start whole-buffer zeroing
//   busy                                 : clear sweep in progress
//   sat_flag                             : sticky saturation indicator
// -----------------------------------------------------------------------------
interface psum_accum_buffer_if #(
    parameter int ARRAY_DIM  = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                           acc_valid;
    logic                           acc_clear;
    logic [ADDR_WIDTH-1:0]          acc_addr;
    logic [ARRAY_DIM*ACC_WIDTH-1:0] psum_in;
    logic                           rd_req;
    logic                           rd_clear;
    logic [ADDR_WIDTH-1:0]          rd_addr;
    logic                           rd_ready;
    logic                           rd_valid;
    logic [ARRAY_DIM*ACC_WIDTH-1:0] rd_data;
    logic                           clear_all;
    logic                           busy;
    logic                           sat_flag;

    modport master (
        output acc_valid, acc_clear, acc_addr, psum_in,
        output rd_req, rd_clear, rd_addr, clear_all,
        input  rd_ready, rd_valid, rd_data, busy, sat_flag
    );

    modport slave (
        input  acc_valid, acc_clear, acc_addr, psum_in,
        input  rd_req, rd_clear, rd_addr, clear_all,
        output rd_ready, rd_valid, rd_data, busy, sat_flag
    );
endinterface

// File: rtl/psum_accum_buffer.sv
// -----------------------------------------------------------------------------
// psum_accum_buffer
//   Partial-sum accumulation buffer between the PE array column outputs and the
//   writeback path. Each word holds ARRAY_DIM two's-complement lanes.
//   Accumulate ops do read-add-write (or overwrite with acc_clear); readout ops
//   return a word (optionally zeroing it). One op per cycle, accumulate wins
//   over readout. A clear sequencer zeroes the whole buffer on clear_all.
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : psum_accum_buffer_if.slave (accumulate, readout, clear control)
// Pipeline
//   edge T   : op registered into S1, memory read (registered) into S1
//   edge T+1 : lane math on S1 contents, memory write, rd_data/rd_valid update
//   An op issued at T+1 to the address written at T+1 takes the write data
//   through a bypass register instead of the stale memory read.
// -----------------------------------------------------------------------------
module psum_accum_buffer #(
    parameter int ARRAY_DIM  = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int SATURATE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    psum_accum_buffer_if.slave      bus
);
    localparam int WORD_WIDTH = ARRAY_DIM * ACC_WIDTH;
    localparam int IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]    DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_WIDTH-1:0]   LAST_IDX    = IDX_WIDTH'(DEPTH - 1);
    localparam logic [ACC_WIDTH-1:0]   LANE_MAX    = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0]   LANE_MIN    = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [IDX_WIDTH-1:0]   clr_idx_reg, clr_idx_next;

    logic [WORD_WIDTH-1:0]  mem [DEPTH];

    // Issue stage
    logic                   busy;
    logic                   acc_fire;
    logic                   rd_fire;
    logic                   issue;
    logic [ADDR_WIDTH-1:0]  issue_addr;
    logic                   issue_in_range;
    logic [IDX_WIDTH-1:0]   issue_idx;

    // S1 registers
    logic                   s1_valid_reg;
    logic                   s1_is_rd_reg;
    logic                   s1_clear_reg;
    logic [ADDR_WIDTH-1:0]  s1_addr_reg;
    logic                   s1_in_range_reg;
    logic [WORD_WIDTH-1:0]  s1_psum_reg;
    logic [WORD_WIDTH-1:0]  s1_mem_rd_reg;
    logic                   s1_fwd_reg;
    logic [WORD_WIDTH-1:0]  s1_fwd_data_reg;

    // Write stage
    logic [WORD_WIDTH-1:0]  old_word;
    logic [WORD_WIDTH-1:0]  op_wr_data;
    logic [ARRAY_DIM-1:0]   lane_ovf;
    logic                   op_wr_en;
    logic                   sweep_wr;
    logic                   wr_en;
    logic [IDX_WIDTH-1:0]   wr_idx;
    logic [WORD_WIDTH-1:0]  wr_data;
    logic                   fwd_hit;

    // Outputs
    logic                   rd_valid_reg;
    logic [WORD_WIDTH-1:0]  rd_data_reg;
    logic                   sat_flag_reg;

    // ---------------------------------------------------------------- issue
    assign busy           = (state_reg == ST_CLEAR);
    assign acc_fire       = bus.acc_valid & ~busy;
    assign rd_fire        = bus.rd_req & ~bus.acc_valid & ~busy;
    assign issue          = acc_fire | rd_fire;
    assign issue_addr     = acc_fire ? bus.acc_addr : bus.rd_addr;
    assign issue_in_range = ({1'b0, issue_addr} < DEPTH_LIMIT);
    // Out-of-range addresses read a harmless in-range word; the result is masked.
    assign issue_idx      = issue_in_range ? issue_addr[IDX_WIDTH-1:0] : '0;

    // The op in S1 writes at the same edge the new op is issued: bypass it.
    assign fwd_hit = issue & op_wr_en & (s1_addr_reg == issue_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= issue;
        end
        s1_is_rd_reg    <= ~acc_fire;
        s1_clear_reg    <= acc_fire ? bus.acc_clear : bus.rd_clear;
        s1_addr_reg     <= issue_addr;
        s1_in_range_reg <= issue_in_range;
        s1_psum_reg     <= bus.psum_in;
        s1_fwd_reg      <= fwd_hit;
        s1_fwd_data_reg <= op_wr_data;
    end

    // ---------------------------------------------------------------- memory
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        s1_mem_rd_reg <= mem[issue_idx];
    end

    // ---------------------------------------------------------------- lane math
    assign old_word = !s1_in_range_reg ? '0 :
                      (s1_fwd_reg ? s1_fwd_data_reg : s1_mem_rd_reg);

    generate
        for (genvar gi = 0; gi < ARRAY_DIM; gi++) begin : g_lane
            logic [ACC_WIDTH-1:0] old_lane;
            logic [ACC_WIDTH-1:0] in_lane;
            logic [ACC_WIDTH-1:0] sum_lane;
            logic [ACC_WIDTH-1:0] new_lane;
            logic                 ovf;

            assign old_lane = old_word[gi*ACC_WIDTH +: ACC_WIDTH];
            assign in_lane  = s1_psum_reg[gi*ACC_WIDTH +: ACC_WIDTH];
            assign sum_lane = old_lane + in_lane;
            // Signed overflow: operands agree in sign, result does not.
            assign ovf = (old_lane[ACC_WIDTH-1] == in_lane[ACC_WIDTH-1]) &&
                         (sum_lane[ACC_WIDTH-1] != old_lane[ACC_WIDTH-1]);

            always_comb begin
                new_lane = sum_lane;
                if (s1_is_rd_reg) begin
                    // Only ever written back for a clearing readout.
                    new_lane = '0;
                end else if (s1_clear_reg) begin
                    new_lane = in_lane;
                end else if ((SATURATE != 0) && ovf) begin
                    new_lane = old_lane[ACC_WIDTH-1] ? LANE_MIN : LANE_MAX;
                end
            end

            assign op_wr_data[gi*ACC_WIDTH +: ACC_WIDTH] = new_lane;
            assign lane_ovf[gi] = ovf & ~s1_is_rd_reg & ~s1_clear_reg;
        end
    endgenerate

    // ---------------------------------------------------------------- write port
    assign op_wr_en = s1_valid_reg & s1_in_range_reg & (~s1_is_rd_reg | s1_clear_reg);
    // The sweep waits until the op that was in flight at entry has written.
    assign sweep_wr = busy & ~s1_valid_reg;
    assign wr_en    = (op_wr_en | sweep_wr) & ~rst;
    assign wr_idx   = sweep_wr ? clr_idx_reg : s1_addr_reg[IDX_WIDTH-1:0];
    assign wr_data  = sweep_wr ? '0 : op_wr_data;

    // ---------------------------------------------------------------- readout / flags
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
            sat_flag_reg <= 1'b0;
        end else begin
            rd_valid_reg <= s1_valid_reg & s1_is_rd_reg;
            if (s1_valid_reg & s1_is_rd_reg) begin
                rd_data_reg <= old_word;
            end
            if ((SATURATE != 0) && s1_valid_reg && s1_in_range_reg && (|lane_ovf)) begin
                sat_flag_reg <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- clear sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.clear_all) begin
                    state_next   = ST_CLEAR;
                    clr_idx_next = '0;
                end
            end
            ST_CLEAR: begin
                if (sweep_wr) begin
                    if (clr_idx_reg == LAST_IDX) begin
                        state_next = ST_IDLE;
                    end else begin
                        clr_idx_next = clr_idx_reg + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.rd_ready = rd_fire;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.rd_data  = rd_data_reg;
    assign bus.busy     = busy;
    assign bus.sat_flag = sat_flag_reg;

endmodule

// File: tb/tb_psum_accum_buffer.sv
// -----------------------------------------------------------------------------
// tb_psum_accum_buffer
//   Directed bench for psum_accum_buffer. Two instances share the clock/reset:
//   dut0 wraps on overflow, dut1 saturates. 4 lanes x 32 bits, 256 words,
//   9-bit address so that out-of-range addresses can be exercised.
// -----------------------------------------------------------------------------
module tb_psum_accum_buffer;
    localparam int AD = 4;
    localparam int AW = 32;
    localparam int DP = 256;
    localparam int ABITS = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    psum_accum_buffer_if #(.ARRAY_DIM(AD), .ACC_WIDTH(AW), .ADDR_WIDTH(ABITS)) bus0();
    psum_accum_buffer_if #(.ARRAY_DIM(AD), .ACC_WIDTH(AW), .ADDR_WIDTH(ABITS)) bus1();

    psum_accum_buffer #(
        .ARRAY_DIM(AD), .ACC_WIDTH(AW), .DEPTH(DP), .ADDR_WIDTH(ABITS), .SATURATE(0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    psum_accum_buffer #(
        .ARRAY_DIM(AD), .ACC_WIDTH(AW), .DEPTH(DP), .ADDR_WIDTH(ABITS), .SATURATE(1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus0.acc_valid = 1'b0; bus0.acc_clear = 1'b0; bus0.acc_addr = '0; bus0.psum_in = '0;
        bus0.rd_req = 1'b0; bus0.rd_clear = 1'b0; bus0.rd_addr = '0; bus0.clear_all = 1'b0;
        bus1.acc_valid = 1'b0; bus1.acc_clear = 1'b0; bus1.acc_addr = '0; bus1.psum_in = '0;
        bus1.rd_req = 1'b0; bus1.rd_clear = 1'b0; bus1.rd_addr = '0; bus1.clear_all = 1'b0;
    endtask

    // One accumulate op, issued at the next rising edge.
    task automatic drive_acc(input bit which, input logic [ABITS-1:0] a, input bit clr,
                             input logic [AD*AW-1:0] w);
        if (which) begin
            bus1.acc_valid = 1'b1; bus1.acc_clear = clr; bus1.acc_addr = a; bus1.psum_in = w;
        end else begin
            bus0.acc_valid = 1'b1; bus0.acc_clear = clr; bus0.acc_addr = a; bus0.psum_in = w;
        end
        step();
        if (which) begin
            bus1.acc_valid = 1'b0; bus1.acc_clear = 1'b0;
        end else begin
            bus0.acc_valid = 1'b0; bus0.acc_clear = 1'b0;
        end
    endtask

    // Readout: hold rd_req until accepted (bounded), then collect rd_data when
    // rd_valid shows up two edges after acceptance. ok=0 if anything timed out.
    task automatic do_read(input bit which, input logic [ABITS-1:0] a, input bit clr,
                           output logic [AD*AW-1:0] data, output bit ok);
        int waits;
        logic rdy;
        waits = 0;
        ok    = 1'b0;
        data  = 'x;
        if (which) begin
            bus1.rd_req = 1'b1; bus1.rd_clear = clr; bus1.rd_addr = a;
        end else begin
            bus0.rd_req = 1'b1; bus0.rd_clear = clr; bus0.rd_addr = a;
        end
        #1;
        rdy = which ? bus1.rd_ready : bus0.rd_ready;
        while (!rdy && waits < 1000) begin
            step();
            waits++;
            rdy = which ? bus1.rd_ready : bus0.rd_ready;
        end
        if (rdy) begin
            step();
            if (which) begin
                bus1.rd_req = 1'b0; bus1.rd_clear = 1'b0;
            end else begin
                bus0.rd_req = 1'b0; bus0.rd_clear = 1'b0;
            end
            step();
            if (which ? bus1.rd_valid : bus0.rd_valid) begin
                ok   = 1'b1;
                data = which ? bus1.rd_data : bus0.rd_data;
            end
        end else begin
            bus0.rd_req = 1'b0; bus0.rd_clear = 1'b0;
            bus1.rd_req = 1'b0; bus1.rd_clear = 1'b0;
        end
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        repeat (3) step();
        n_checks++;
        if (bus0.rd_valid !== 1'b0) begin
            $display("FAIL reset_rd_valid: got %b expected 0", bus0.rd_valid); n_fail++;
        end
        n_checks++;
        if (bus0.rd_data !== '0) begin
            $display("FAIL reset_rd_data: got %h expected 0", bus0.rd_data); n_fail++;
        end
        n_checks++;
        if (bus0.busy !== 1'b0) begin
            $display("FAIL reset_busy: got %b expected 0", bus0.busy); n_fail++;
        end
        n_checks++;
        if (bus1.sat_flag !== 1'b0 || bus0.sat_flag !== 1'b0) begin
            $display("FAIL reset_sat_flag: got %b/%b expected 0/0", bus0.sat_flag, bus1.sat_flag); n_fail++;
        end
        rst = 1'b0;
        step();
        bus0.rd_req = 1'b1;
        #1;
        n_checks++;
        if (bus0.rd_ready !== 1'b1) begin
            $display("FAIL idle_rd_ready: got %b expected 1", bus0.rd_ready); n_fail++;
        end
        bus0.rd_req = 1'b0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        logic [AD*AW-1:0] got;
        bit ok;
        drive_acc(0, 9'd5, 1'b1, {AD{32'd10}});
        drive_acc(0, 9'd5, 1'b0, {AD{32'd3}});
        drive_acc(0, 9'd5, 1'b0, {AD{32'd4}});
        do_read(0, 9'd5, 1'b0, got, ok);
        n_checks++;
        if (!ok || got !== {AD{32'd17}}) begin
            $display("FAIL back_to_back_raw: got %h (ok=%0d) expected %h", got, ok, {AD{32'd17}}); n_fail++;
        end
        $display("test_back_to_back: addr 5 -> %h", got);
    endtask

    task automatic test_gaps();
        logic [AD*AW-1:0] got;
        bit ok;
        for (int gap = 1; gap <= 2; gap++) begin
            logic [ABITS-1:0] a;
            a = (gap == 1) ? 9'd6 : 9'd8;
            drive_acc(0, a, 1'b1, {AD{32'd10}});
            repeat (gap) step();
            drive_acc(0, a, 1'b0, {AD{32'd3}});
            repeat (gap) step();
            drive_acc(0, a, 1'b0, {AD{32'd4}});
            repeat (gap) step();
            do_read(0, a, 1'b0, got, ok);
            n_checks++;
            if (!ok || got !== {AD{32'd17}}) begin
                $display("FAIL gap%0d_raw: got %h (ok=%0d) expected %h", gap, got, ok, {AD{32'd17}}); n_fail++;
            end
            $display("test_gaps: gap %0d addr %0d -> %h", gap, a, got);
        end
    endtask

    task automatic test_lanes();
        logic [AD*AW-1:0] got;
        logic [AD*AW-1:0] exp;
        bit ok;
        drive_acc(0, 9'd7, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1});
        drive_acc(0, 9'd7, 1'b0, {32'd1000, 32'd100, 32'd10, 32'hFFFF_FFFF});
        exp = {32'd1004, 32'd103, 32'd12, 32'd0};
        do_read(0, 9'd7, 1'b0, got, ok);
        n_checks++;
        if (!ok || got !== exp) begin
            $display("FAIL lane_independence: got %h (ok=%0d) expected %h", got, ok, exp); n_fail++;
        end
        $display("test_lanes: addr 7 -> %h", got);
    endtask

    task automatic test_saturation();
        logic [AD*AW-1:0] got;
        logic [AD*AW-1:0] exp_sat;
        logic [AD*AW-1:0] exp_wrap;
        bit ok;
        exp_sat  = {32'd0, 32'd10, 32'h8000_0000, 32'h7FFF_FFFF};
        exp_wrap = {32'd0, 32'd10, 32'h0000_0005, 32'h8000_0010};
        for (int w = 1; w >= 0; w--) begin
            drive_acc(w[0], 9'd3, 1'b1, {32'd0, 32'd5, 32'h8000_0005, 32'h7FFF_FFF0});
            step();
            if (w == 1) begin
                n_checks++;
                if (bus1.sat_flag !== 1'b0) begin
                    $display("FAIL sat_flag_before_overflow: got %b expected 0", bus1.sat_flag); n_fail++;
                end
            end
            drive_acc(w[0], 9'd3, 1'b0, {32'd0, 32'd5, 32'h8000_0000, 32'h0000_0020});
            do_read(w[0], 9'd3, 1'b0, got, ok);
            n_checks++;
            if (!ok || got !== (w == 1 ? exp_sat : exp_wrap)) begin
                $display("FAIL sat_data_SAT%0d: got %h (ok=%0d) expected %h", w, got, ok,
                         (w == 1 ? exp_sat : exp_wrap)); n_fail++;
            end
            n_checks++;
            if ((w == 1 ? bus1.sat_flag : bus0.sat_flag) !== (w == 1)) begin
                $display("FAIL sat_flag_SAT%0d: got %b expected %0d", w,
                         (w == 1 ? bus1.sat_flag : bus0.sat_flag), w); n_fail++;
            end
            $display("test_saturation: SATURATE=%0d -> %h", w, got);
        end
    endtask

    task automatic test_out_of_range();
        logic [AD*AW-1:0] got;
        bit ok;
        drive_acc(0, 9'd44, 1'b1, {AD{32'd9}});
        drive_acc(0, 9'd300, 1'b1, {AD{32'd55}});
        do_read(0, 9'd300, 1'b0, got, ok);
        n_checks++;
        if (!ok || got !== '0) begin
            $display("FAIL oob_read: got %h (ok=%0d) expected 0", got, ok); n_fail++;
        end
        do_read(0, 9'd44, 1'b0, got, ok);
        n_checks++;
        if (!ok || got !== {AD{32'd9}}) begin
            $display("FAIL oob_no_alias: got %h (ok=%0d) expected %h", got, ok, {AD{32'd9}}); n_fail++;
        end
        $display("test_out_of_range: addr 300 dropped, addr 44 -> %h", got);
    endtask

    task automatic test_arbitration();
        logic [AD*AW-1:0] got;
        bit ok;
        bus0.acc_valid = 1'b1; bus0.acc_clear = 1'b1; bus0.acc_addr = 9'd9; bus0.psum_in = {AD{32'd1}};
        bus0.rd_req = 1'b1; bus0.rd_clear = 1'b0; bus0.rd_addr = 9'd9;
        #1;
        n_checks++;
        if (bus0.rd_ready !== 1'b0) begin
            $display("FAIL arb_rd_ready_blocked: got %b expected 0", bus0.rd_ready); n_fail++;
        end
        step();
        bus0.acc_valid = 1'b0; bus0.acc_clear = 1'b0;
        #1;
        n_checks++;
        if (bus0.rd_ready !== 1'b1) begin
            $display("FAIL arb_rd_ready_free: got %b expected 1", bus0.rd_ready); n_fail++;
        end
        step();
        bus0.rd_req = 1'b0;
        n_checks++;
        if (bus0.rd_valid !== 1'b0) begin
            $display("FAIL arb_rd_valid_early: got %b expected 0", bus0.rd_valid); n_fail++;
        end
        step();
        n_checks++;
        if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== {AD{32'd1}}) begin
            $display("FAIL arb_held_read: valid %b data %h expected 1 / %h", bus0.rd_valid, bus0.rd_data,
                     {AD{32'd1}}); n_fail++;
        end
        step();
        n_checks++;
        if (bus0.rd_valid !== 1'b0) begin
            $display("FAIL arb_rd_valid_pulse: got %b expected 0", bus0.rd_valid); n_fail++;
        end
        do_read(0, 9'd9, 1'b1, got, ok);
        n_checks++;
        if (!ok || got !== {AD{32'd1}}) begin
            $display("FAIL rd_clear_first: got %h (ok=%0d) expected %h", got, ok, {AD{32'd1}}); n_fail++;
        end
        do_read(0, 9'd9, 1'b0, got, ok);
        n_checks++;
        if (!ok || got !== '0) begin
            $display("FAIL rd_clear_second: got %h (ok=%0d) expected 0", got, ok); n_fail++;
        end
        $display("test_arbitration: after rd_clear addr 9 -> %h", got);
    endtask

    task automatic test_clear_all();
        logic [AD*AW-1:0] got;
        bit ok;
        int cnt;
        logic [ABITS-1:0] probe [3];
        probe[0] = 9'd0; probe[1] = 9'd100; probe[2] = 9'd255;
        for (int a = 0; a < DP; a++) begin
            drive_acc(0, ABITS'(a), 1'b1, {AD{32'(a + 1)}});
        end
        bus0.clear_all = 1'b1;
        step();
        bus0.clear_all = 1'b0;
        bus0.rd_req = 1'b1; bus0.rd_addr = 9'd1;
        #1;
        n_checks++;
        if (bus0.rd_ready !== 1'b0) begin
            $display("FAIL clear_rd_ready: got %b expected 0", bus0.rd_ready); n_fail++;
        end
        bus0.rd_req = 1'b0;
        cnt = 0;
        while (bus0.busy && cnt < 1000) begin
            cnt++;
            step();
        end
        n_checks++;
        if (cnt != DP) begin
            $display("FAIL clear_busy_cycles: got %0d expected %0d", cnt, DP); n_fail++;
        end
        $display("test_clear_all: busy for %0d cycles", cnt);
        for (int i = 0; i < 3; i++) begin
            do_read(0, probe[i], 1'b0, got, ok);
            n_checks++;
            if (!ok || got !== '0) begin
                $display("FAIL clear_read_addr%0d: got %h (ok=%0d) expected 0", probe[i], got, ok); n_fail++;
            end
            $display("test_clear_all: addr %0d -> %h", probe[i], got);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [AD*AW-1:0] got;
        bit ok;
        drive_acc(0, 9'd50, 1'b1, {AD{32'h111}});
        drive_acc(0, 9'd150, 1'b1, {AD{32'hABC}});
        step();
        bus0.clear_all = 1'b1;
        step();
        bus0.clear_all = 1'b0;
        repeat (100) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (bus0.busy !== 1'b0) begin
            $display("FAIL reset_mid_clear_busy: got %b expected 0", bus0.busy); n_fail++;
        end
        n_checks++;
        if (bus0.rd_valid !== 1'b0) begin
            $display("FAIL reset_mid_clear_rd_valid: got %b expected 0", bus0.rd_valid); n_fail++;
        end
        step();
        do_read(0, 9'd150, 1'b0, got, ok);
        n_checks++;
        if (!ok || got !== {AD{32'hABC}}) begin
            $display("FAIL reset_mid_clear_addr150: got %h (ok=%0d) expected %h", got, ok, {AD{32'hABC}}); n_fail++;
        end
        $display("test_reset_mid_clear: addr 150 -> %h", got);
        do_read(0, 9'd50, 1'b0, got, ok);
        n_checks++;
        if (!ok || got !== '0) begin
            $display("FAIL reset_mid_clear_addr50: got %h (ok=%0d) expected 0", got, ok); n_fail++;
        end
        $display("test_reset_mid_clear: addr 50 -> %h", got);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_lanes();
        test_saturation();
        test_out_of_range();
        test_arbitration();
        test_clear_all();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
